// File: rtl/mpp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpp_pkg
// Description : Shared constants for the MPP program memory. Holds the FSM
//               state encoding, the position of the program-read strobe on
//               the CPU control bus, and the NOP opcode.
// Revision    : 1.0 - initial release
// ============================================================================
package mpp_pkg;

    // FSM state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_fetch = 2'd2;

    // Bit of out_signals that carries the program read strobe
    localparam int c_strobe_bit = 1;

    // Opcode returned for fetches outside the populated storage
    localparam logic [7:0] c_nop = 8'h00;

endpackage : mpp_pkg
`default_nettype wire

// File: rtl/mpp_prog_ram.sv
`default_nettype none
// ============================================================================
// Module      : mpp_prog_ram
// Description : Simple dual-port program storage. One synchronous write port,
//               one registered read port. No reset, so contents persist
//               across resets of the surrounding logic.
// Revision    : 1.0 - initial release
// ============================================================================
module mpp_prog_ram #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_W-1:0]    rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_BITS)-1];

    // Write port: store a byte when enabled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered, holds its value when not enabled
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule : mpp_prog_ram
`default_nettype wire

// File: rtl/mpp_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : mpp_prog_mem
// Description : Program memory for the MPP CPU. A host loads bytes
//               sequentially in LOAD; the CPU fetches one byte per rising
//               edge of its read strobe. Fetch result appears with a single
//               cycle fetch_valid pulse two clocks after the strobe rise.
// Revision    : 1.0 - initial release
// ============================================================================
module mpp_prog_mem
    import mpp_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       program_addr,
    input  logic [4:0]        out_signals,
    output logic [DATA_W-1:0] instruction,
    output logic              fetch_valid,
    input  logic              load_en,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_start,
    input  logic              load_done,
    output logic              load_full,
    output logic              busy
);

    // Depth compared against the full 16-bit address so high addresses never alias
    localparam logic [16:0]          c_depth = 17'(2**ADDR_BITS);
    localparam logic [ADDR_BITS-1:0] c_last  = '1;

    logic [1:0]           r_state;
    logic                 r_strobe_d;
    logic                 r_armed;
    logic [15:0]          r_addr;
    logic [ADDR_BITS-1:0] r_ptr;
    logic                 r_full;
    logic                 r_fetch_valid;
    logic [DATA_W-1:0]    r_instr;

    logic                 w_strobe;
    logic                 w_rise;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic                 w_in_range;
    logic [DATA_W-1:0]    w_ram_q;
    logic                 w_unused;

    assign w_strobe   = out_signals[c_strobe_bit];
    // r_armed suppresses a false edge on the first sample after reset release
    assign w_rise     = r_armed & w_strobe & ~r_strobe_d;
    assign w_wr_en    = (r_state == c_st_load) & load_en & ~r_full;
    // RAM read is launched on the edge itself so data is ready in FETCH
    assign w_rd_en    = (r_state == c_st_idle) & w_rise & ~load_start;
    assign w_in_range = ({1'b0, r_addr} < c_depth);
    assign w_unused   = &{1'b0, out_signals[4:2], out_signals[0]};

    assign instruction = r_instr;
    assign fetch_valid = r_fetch_valid;
    assign load_full   = r_full;
    assign busy        = (r_state == c_st_load);

    mpp_prog_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (r_ptr),
        .wr_data (load_data),
        .rd_en   (w_rd_en),
        .rd_addr (program_addr[ADDR_BITS-1:0]),
        .rd_data (w_ram_q)
    );

    // Strobe history: tracks the strobe in every state, so leaving LOAD never sees a stale edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe_d <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_strobe_d <= w_strobe;
            r_armed    <= 1'b1;
        end
    end

    // Control FSM: fetch sequencing, load pointer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_addr        <= 16'h0000;
            r_ptr         <= '0;
            r_full        <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_instr       <= DATA_W'(c_nop);
        end else begin
            r_fetch_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (load_start) begin
                        r_ptr   <= '0;
                        r_full  <= 1'b0;
                        r_state <= c_st_load;
                    end else if (w_rise) begin
                        r_addr  <= program_addr;
                        r_state <= c_st_fetch;
                    end
                end
                c_st_load: begin
                    if (w_wr_en) begin
                        // Pointer parks on the last location; load_full blocks further writes
                        if (r_ptr == c_last) begin
                            r_full <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                    if (load_done) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_fetch: begin
                    r_instr       <= w_in_range ? w_ram_q : DATA_W'(c_nop);
                    r_fetch_valid <= 1'b1;
                    r_state       <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule : mpp_prog_mem
`default_nettype wire

// File: tb/tb_mpp_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpp_prog_mem
// Description : Self-checking bench for mpp_prog_mem. A byte-array model of
//               the storage plus load pointer predicts every fetch result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpp_prog_mem;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] program_addr;
    logic [4:0]  out_signals;
    logic [7:0]  instruction;
    logic        fetch_valid;
    logic        load_en;
    logic [7:0]  load_data;
    logic        load_start;
    logic        load_done;
    logic        load_full;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    logic [7:0] ref_mem [DEPTH];
    bit         ref_vld [DEPTH];
    int         ref_ptr;
    bit         ref_full;
    logic [7:0] ref_instr;

    always #5 clk = ~clk;

    mpp_prog_mem #(.ADDR_BITS(8), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .program_addr (program_addr),
        .out_signals  (out_signals),
        .instruction  (instruction),
        .fetch_valid  (fetch_valid),
        .load_en      (load_en),
        .load_data    (load_data),
        .load_start   (load_start),
        .load_done    (load_done),
        .load_full    (load_full),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_fetch(input logic [15:0] a);
        if (a >= 16'(DEPTH)) return 8'h00;
        return ref_mem[a];
    endfunction

    // Drive the strobe bit, randomising the ignored control bits
    task automatic set_strobe(input bit s);
        logic [4:0] v;
        v = 5'($urandom);
        v[1] = s;
        out_signals = v;
    endtask

    task automatic model_write(input logic [7:0] d);
        if (!ref_full) begin
            ref_mem[ref_ptr] = d;
            ref_vld[ref_ptr] = 1'b1;
            if (ref_ptr == DEPTH-1) ref_full = 1'b1;
            else ref_ptr++;
        end
    endtask

    task automatic load_begin();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        ref_ptr = 0;
        ref_full = 1'b0;
        check("busy_on_start", 32'(busy), 32'd1);
        check("full_clr_start", 32'(load_full), 32'd0);
    endtask

    task automatic load_byte(input logic [7:0] d);
        load_en = 1'b1;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        model_write(d);
        check("load_full", 32'(load_full), 32'(ref_full));
    endtask

    // load_done, optionally carrying a final byte in the same cycle
    task automatic load_end(input bit with_byte, input logic [7:0] d);
        load_done = 1'b1;
        load_en = with_byte;
        load_data = d;
        @(negedge clk);
        if (with_byte) model_write(d);
        load_done = 1'b0;
        load_en = 1'b0;
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    // Strobe rise -> fetch_valid exactly two clocks later; strobe then dropped
    task automatic fetch(input logic [15:0] a);
        program_addr = a;
        set_strobe(1'b1);
        @(negedge clk);
        check("fv_early", 32'(fetch_valid), 32'd0);
        @(negedge clk);
        ref_instr = model_fetch(a);
        check("fv_pulse", 32'(fetch_valid), 32'd1);
        check($sformatf("instr@%0h", a), 32'(instruction), 32'(ref_instr));
        set_strobe(1'b0);
        program_addr = 16'($urandom);
        @(negedge clk);
        check("fv_drop", 32'(fetch_valid), 32'd0);
        check("instr_hold", 32'(instruction), 32'(ref_instr));
    endtask

    initial begin
        logic [7:0] prog [5];
        int fv_cnt;
        logic [15:0] a;
        prog[0] = 8'h07; prog[1] = 8'hC0; prog[2] = 8'h44; prog[3] = 8'hC1; prog[4] = 8'hCB;
        for (int i = 0; i < DEPTH; i++) ref_vld[i] = 1'b0;
        ref_ptr = 0; ref_full = 1'b0; ref_instr = 8'h00;

        rst_n = 1'b0; program_addr = 16'h0; out_signals = 5'h0;
        load_en = 1'b0; load_data = 8'h0; load_start = 1'b0; load_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_instr", 32'(instruction), 32'h0);
        check("rst_fv", 32'(fetch_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(load_full), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed program load; last byte rides with load_done
        load_begin();
        for (int i = 0; i < 4; i++) load_byte(prog[i]);
        load_end(1'b1, prog[4]);
        @(negedge clk);
        for (int i = 0; i < 5; i++) fetch(16'(i));

        // Out-of-range fetch returns NOP
        fetch(16'h0100);

        // Strobe held high for 10 cycles gives exactly one fetch
        program_addr = 16'h0003;
        set_strobe(1'b1);
        fv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fetch_valid) fv_cnt++;
            set_strobe(1'b1);
        end
        set_strobe(1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (fetch_valid) fv_cnt++;
        end
        check("held_one_fetch", 32'(fv_cnt), 32'd1);
        check("held_instr", 32'(instruction), 32'h0000_00C1);
        ref_instr = 8'hC1;

        // Full load of 257 random bytes; byte 257 dropped
        load_begin();
        for (int i = 0; i < 257; i++) load_byte(8'($urandom));
        load_end(1'b0, 8'h00);
        @(negedge clk);
        fetch(16'h00FF);
        fetch(16'h0000);

        // Random fetch sweep over in-range and out-of-range addresses
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(256, 65535));
            else a = 16'($urandom_range(0, 255));
            fetch(a);
        end

        // Strobe edges during LOAD are ignored; strobe rising on the exit cycle is not stale
        load_begin();
        fv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            set_strobe(i[0]);
            program_addr = 16'($urandom_range(0, 255));
            load_byte(8'($urandom));
            if (fetch_valid) fv_cnt++;
        end
        set_strobe(1'b0);
        @(negedge clk);
        set_strobe(1'b1);
        load_end(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (fetch_valid) fv_cnt++;
            set_strobe(1'b1);
        end
        check("no_fetch_in_load", 32'(fv_cnt), 32'd0);
        set_strobe(1'b0);
        @(negedge clk);
        fetch(16'h0002);

        // load_start wins over a simultaneous strobe edge
        program_addr = 16'h0001;
        set_strobe(1'b1);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        ref_ptr = 0; ref_full = 1'b0;
        check("prio_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("prio_no_fv", 32'(fetch_valid), 32'd0);
        set_strobe(1'b0);
        load_end(1'b0, 8'h00);
        @(negedge clk);

        // load_start during FETCH is ignored
        program_addr = 16'h0004;
        set_strobe(1'b1);
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("fetch_ign_start_fv", 32'(fetch_valid), 32'd1);
        check("fetch_ign_start_busy", 32'(busy), 32'd0);
        check("fetch_ign_start_instr", 32'(instruction), 32'(model_fetch(16'h0004)));
        set_strobe(1'b0);
        @(negedge clk);

        // Reset in the middle of LOAD: outputs clear, stored bytes survive
        load_begin();
        for (int i = 0; i < 3; i++) load_byte(8'($urandom));
        rst_n = 1'b0;
        #1;
        check("midload_rst_busy", 32'(busy), 32'd0);
        check("midload_rst_instr", 32'(instruction), 32'h0);
        check("midload_rst_full", 32'(load_full), 32'd0);
        check("midload_rst_fv", 32'(fetch_valid), 32'd0);
        ref_ptr = 0; ref_full = 1'b0; ref_instr = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) fetch(16'(i));

        // Strobe high across reset release is not an edge
        rst_n = 1'b0;
        program_addr = 16'h0001;
        set_strobe(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        fv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (fetch_valid) fv_cnt++;
            set_strobe(1'b1);
        end
        check("rst_release_no_edge", 32'(fv_cnt), 32'd0);
        set_strobe(1'b0);
        @(negedge clk);
        fetch(16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the run can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_mpp_prog_mem
`default_nettype wire

// File: doc/mpp_prog_mem.md
MPP_PROG_MEM -- requirements
Module: mpp_prog_mem

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning log2 of storage depth (256 bytes).
REQ-002 SHALL have parameter DATA_W, default 8, meaning instruction byte width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port program_addr, input, 16, the CPU fetch address.
REQ-006 SHALL have port out_signals, input, 5, the CPU control bus; bit1 is the program read strobe (active high); other bits are ignored.
REQ-007 SHALL have port instruction, output, DATA_W, the fetched instruction byte.
REQ-008 SHALL have port fetch_valid, output, 1, high for one cycle when instruction holds a fresh fetch result.
REQ-009 SHALL have port load_en, input, 1, a host byte-write strobe.
REQ-010 SHALL have port load_data, input, DATA_W, the byte to store.
REQ-011 SHALL have port load_start, input, 1, a pulse that clears the load pointer and enters LOAD.
REQ-012 SHALL have port load_done, input, 1, a pulse that leaves LOAD.
REQ-013 SHALL have port load_full, output, 1, high when the load pointer has passed the last location.
REQ-014 SHALL have port busy, output, 1, high while in LOAD.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, FETCH; the reset state is IDLE.
REQ-016 IDLE: a rising edge of strobe (bit1 high, previous cycle low) SHALL latch program_addr and go to FETCH.
REQ-017 FETCH: instruction SHALL be driven from the latched address and fetch_valid pulsed for 1 cycle, then return to IDLE; latency strobe-rise to fetch_valid is 2 clocks.
REQ-018 A strobe held high SHALL produce exactly one fetch; a new fetch requires strobe low for at least 1 cycle.
REQ-019 A latched address at or above 2**ADDR_BITS SHALL return 0x00 (NOP) and never alias.
REQ-020 instruction SHALL hold its last value between fetches.
REQ-021 IDLE + load_start SHALL clear the pointer and load_full, then go to LOAD; load_start takes priority over a simultaneous strobe edge.
REQ-022 LOAD: each cycle with load_en high and load_full low SHALL write load_data at the pointer and increment the pointer.
REQ-023 Writing the last location SHALL set load_full; the pointer SHALL NOT wrap; further load_en bytes SHALL be dropped.
REQ-024 LOAD: strobe edges SHALL be ignored (no fetch_valid); the edge detector keeps tracking the strobe so there is no stale edge on exit.
REQ-025 LOAD + load_done SHALL return to IDLE the next cycle; load_en in that same cycle SHALL still be written.
REQ-026 load_start or load_done in FETCH SHALL be ignored.

Reset
REQ-027 rst_n low SHALL force: state IDLE, instruction 0x00, fetch_valid 0, busy 0, load_full 0, pointer 0, strobe history 0, latched address 0.
REQ-028 Reset SHALL NOT clear the storage array; contents survive reset, including a reset asserted mid-LOAD.
REQ-029 Reset release mid-strobe-high SHALL count as a rising edge only if the strobe is sampled low then high after release.

Structure
REQ-030 State encoding, the strobe bit index (1), and the NOP value (0x00) SHALL live in the shared package mpp_pkg.
REQ-031 Storage SHALL be the sub-module mpp_prog_ram: one write port and one registered read port, no reset.

Verification
REQ-032 Load 07 C0 44 C1 CB via load_en, then fetch addr 0..4 -> instruction 07, C0, 44, C1, CB, each with a fetch_valid pulse 2 clocks after the strobe rise.
REQ-033 Fetch addr 0x0100 -> instruction 0x00 with fetch_valid 1.
REQ-034 Write 257 bytes -> load_full rises after byte 256; byte 257 is not stored; addr 0xFF reads byte 256.
REQ-035 Strobe held high for 10 cycles -> exactly one fetch_valid.
REQ-036 Assert rst_n low after 3 bytes in LOAD -> outputs at reset values, busy 0; addr 0..2 fetch the 3 loaded bytes.
REQ-037 Strobe edge during LOAD -> no fetch_valid; fetch after load_done -> correct byte.
